// File: rtl/dmem_responder.sv
// Data-memory responder: services byte/half/word/doubleword loads and stores
// from the CPU datapath over a valid/ready request channel. It answers each
// accepted request with a one-cycle response pulse.
// Storage is an array of 32-bit words. A doubleword access takes two word accesses.
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_size        0 byte, 1 half, 2 word, 3 doubleword
//   req_unsigned    zero-extend narrow loads
//   req_addr        64-bit byte address
//   req_wdata       right-aligned store data
//   resp_valid      one-cycle response pulse
//   resp_rdata      formatted load data (0 for stores/errors)
//   resp_err        misaligned or out-of-range request
module dmem_responder #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned BW = AW + 2;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

   state_e            state_q;
   logic              req_ready_q;
   logic              resp_valid_q;
   logic [63:0]       resp_rdata_q;
   logic              resp_err_q;

   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [1:0]        lane_q;
   logic [AW-1:0]     widx_q;
   logic [63:0]       wdata_q;
   logic              err_q;
   logic [31:0]       rd_lo_q;
   logic [31:0]       rd_hi_q;

   logic [3:0][7:0]   mem_q [DEPTH];

   logic              accept_c;
   logic              err_d;
   logic [2:0]        last_off_c;
   logic              misalign_c;
   logic [BW:0]       end_c;
   logic              mem_we_c;
   logic [AW-1:0]     mem_idx_c;
   logic [3:0]        mem_be_c;
   logic [31:0]       mem_wd_c;
   logic [31:0]       lane_word_c;
   logic              sext_c;
   logic [63:0]       load_fmt_c;

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   // Accept-time alignment and range check on the live request fields.
   always_comb begin
      accept_c   = req_valid && req_ready_q;
      last_off_c = 3'd0;
      misalign_c = 1'b0;
      case (req_size)
         2'd1:    begin last_off_c = 3'd1; misalign_c = req_addr[0];     end
         2'd2:    begin last_off_c = 3'd3; misalign_c = |req_addr[1:0];  end
         2'd3:    begin last_off_c = 3'd7; misalign_c = |req_addr[2:0];  end
         default: begin last_off_c = 3'd0; misalign_c = 1'b0;            end
      endcase
      // One extra bit so an access running past the top byte is visible.
      end_c = {1'b0, req_addr[BW-1:0]} + (BW+1)'(last_off_c);
      err_d = misalign_c || (|req_addr[63:BW]) || (end_c >= (BW+1)'(DEPTH * 4));
   end

   // Store lane enables and lane-shifted data for the current access phase.
   always_comb begin
      mem_we_c  = !Reset && we_q && ((state_q == ACC0) || (state_q == ACC1));
      mem_idx_c = widx_q;
      mem_be_c  = 4'b1111;
      mem_wd_c  = wdata_q[31:0] << {lane_q, 3'b000};
      if (state_q == ACC1) begin
         mem_idx_c = widx_q + AW'(1);
         mem_wd_c  = wdata_q[63:32];
      end else begin
         case (size_q)
            2'd0:    mem_be_c = 4'b0001 << lane_q;
            2'd1:    mem_be_c = 4'b0011 << lane_q;
            default: mem_be_c = 4'b1111;
         endcase
      end
   end

   // Load result: lane select then sign/zero extension.
   always_comb begin
      lane_word_c = rd_lo_q >> {lane_q, 3'b000};
      sext_c      = !uns_q;
      case (size_q)
         2'd0:    load_fmt_c = {{56{sext_c & lane_word_c[7]}},  lane_word_c[7:0]};
         2'd1:    load_fmt_c = {{48{sext_c & lane_word_c[15]}}, lane_word_c[15:0]};
         2'd2:    load_fmt_c = {{32{sext_c & rd_lo_q[31]}},     rd_lo_q};
         default: load_fmt_c = {rd_hi_q, rd_lo_q};
      endcase
   end

   // Word storage; not affected by Reset.
   always_ff @(posedge Clk) begin
      if (mem_we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be_c[b]) mem_q[mem_idx_c][b] <= mem_wd_c[8*b +: 8];
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 64'd0;
         resp_err_q   <= 1'b0;
         we_q         <= 1'b0;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         lane_q       <= 2'd0;
         widx_q       <= '0;
         wdata_q      <= 64'd0;
         err_q        <= 1'b0;
         rd_lo_q      <= 32'd0;
         rd_hi_q      <= 32'd0;
      end else begin
         resp_valid_q <= 1'b0;
         // Ready returns the cycle after the response pulse.
         if (resp_valid_q) req_ready_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  req_ready_q <= 1'b0;
                  we_q        <= req_we;
                  size_q      <= req_size;
                  uns_q       <= req_unsigned;
                  lane_q      <= req_addr[1:0];
                  widx_q      <= req_addr[BW-1:2];
                  wdata_q     <= req_wdata;
                  err_q       <= err_d;
                  state_q     <= err_d ? RESP : ACC0;
               end
            end
            ACC0: begin
               rd_lo_q <= mem_q[widx_q];
               state_q <= (size_q == 2'd3) ? ACC1 : RESP;
            end
            ACC1: begin
               rd_hi_q <= mem_q[widx_q + AW'(1)];
               state_q <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= err_q;
               resp_rdata_q <= (err_q || we_q) ? 64'd0 : load_fmt_c;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes the expected response
// and the expected arrival cycle. A monitor pops and compares on every resp_valid.
module tb_dmem_responder;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   dmem_responder #(.DEPTH(1024)) dut (
      .Clk(Clk), .Reset(Reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest expectation, including arrival cycle.
   always @(negedge Clk) begin
      if (!Reset && resp_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=resp_valid@%0d required=none", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("resp_rdata", resp_rdata, mon_e.rdata);
            chk("resp_err", 64'(resp_err), 64'(mon_e.err));
            chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic wait_ready(output logic ok);
      int n = 0;
      @(negedge Clk);
      while (!req_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      ok = req_ready;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 required=1");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout actual=pending%0d required=0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Issue one request and register its expected response and arrival cycle.
   task automatic req(input logic we, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] exp_rd, input logic exp_err);
      logic ok;
      exp_t e;
      int   lat;
      wait_ready(ok);
      if (!ok) return;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      lat          = exp_err ? 1 : ((size == SZ_D) ? 3 : 2);
      e.rdata      = exp_rd;
      e.err        = exp_err;
      e.cyc        = cyc + 1 + lat;
      sb_q.push_back(e);
      @(negedge Clk);
      req_valid = 1'b0;
      drain();
   endtask

   initial begin
      logic ok;
      // Reset state
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_err", 64'(resp_err), 64'd0);
      Reset = 1'b0;

      // 1: word store / signed and unsigned load
      req(1, SZ_W, 0, 64'h10, 64'h00000000_DEADBEEF, 64'd0, 0);
      req(0, SZ_W, 0, 64'h10, 64'd0, 64'hFFFFFFFF_DEADBEEF, 0);
      req(0, SZ_W, 1, 64'h10, 64'd0, 64'h00000000_DEADBEEF, 0);

      // 2: byte and half lanes
      req(1, SZ_W, 0, 64'h20, 64'h11223344, 64'd0, 0);
      req(1, SZ_B, 0, 64'h21, 64'h80, 64'd0, 0);
      req(0, SZ_W, 0, 64'h20, 64'd0, 64'h00000000_11228044, 0);
      req(0, SZ_B, 0, 64'h21, 64'd0, 64'hFFFFFFFF_FFFFFF80, 0);
      req(0, SZ_B, 1, 64'h21, 64'd0, 64'h80, 0);
      req(1, SZ_H, 0, 64'h22, 64'hBEEF, 64'd0, 0);
      req(0, SZ_H, 0, 64'h22, 64'd0, 64'hFFFFFFFF_FFFFBEEF, 0);
      req(0, SZ_H, 1, 64'h22, 64'd0, 64'hBEEF, 0);
      req(0, SZ_W, 0, 64'h20, 64'd0, 64'hFFFFFFFF_BEEF8044, 0);

      // 3: doubleword
      req(1, SZ_D, 0, 64'h40, 64'h01234567_89ABCDEF, 64'd0, 0);
      req(0, SZ_D, 0, 64'h40, 64'd0, 64'h01234567_89ABCDEF, 0);
      req(0, SZ_W, 0, 64'h44, 64'd0, 64'h00000000_01234567, 0);
      req(0, SZ_W, 0, 64'h40, 64'd0, 64'hFFFFFFFF_89ABCDEF, 0);

      // 4: misaligned requests leave memory untouched
      req(1, SZ_W, 0, 64'h00, 64'h11223344, 64'd0, 0);
      req(1, SZ_W, 0, 64'h48, 64'hCAFEF00D, 64'd0, 0);
      req(0, SZ_H, 0, 64'h03, 64'd0, 64'd0, 1);
      req(1, SZ_H, 0, 64'h03, 64'hFFFF, 64'd0, 1);
      req(1, SZ_D, 0, 64'h44, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1);
      req(0, SZ_W, 0, 64'h02, 64'd0, 64'd0, 1);
      req(0, SZ_W, 0, 64'h00, 64'd0, 64'h00000000_11223344, 0);
      req(0, SZ_W, 0, 64'h44, 64'd0, 64'h00000000_01234567, 0);
      req(0, SZ_W, 1, 64'h48, 64'd0, 64'h00000000_CAFEF00D, 0);

      // 5: range boundaries (DEPTH*4 = 0x1000)
      req(0, SZ_D, 0, 64'hFFC, 64'd0, 64'd0, 1);
      req(0, SZ_W, 0, 64'h1_0000_0000, 64'd0, 64'd0, 1);
      req(1, SZ_B, 0, 64'h1000, 64'h12, 64'd0, 1);
      req(1, SZ_D, 0, 64'hFF8, 64'hA5A5A5A5_0F0F0F0F, 64'd0, 0);
      req(0, SZ_D, 0, 64'hFF8, 64'd0, 64'hA5A5A5A5_0F0F0F0F, 0);
      req(1, SZ_W, 0, 64'hFFC, 64'h7EADBEEF, 64'd0, 0);
      req(0, SZ_W, 0, 64'hFFC, 64'd0, 64'h00000000_7EADBEEF, 0);
      req(0, SZ_B, 1, 64'hFFF, 64'd0, 64'h7E, 0);
      req(0, SZ_H, 0, 64'hFFE, 64'd0, 64'h7EAD, 0);

      // 6: reset during the second word of a doubleword store
      req(1, SZ_W, 0, 64'h80, 64'h0, 64'd0, 0);
      req(1, SZ_W, 0, 64'h84, 64'h12345678, 64'd0, 0);
      wait_ready(ok);
      if (ok) begin
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_size  = SZ_D;
         req_addr  = 64'h80;
         req_wdata = 64'hAAAAAAAA_55555555;
         @(negedge Clk);          // ACC0
         req_valid = 1'b0;
         @(negedge Clk);          // ACC1
         Reset = 1'b1;
         @(negedge Clk);          // first cycle after the reset edge
         chk("midrst_ready", 64'(req_ready), 64'd1);
         chk("midrst_valid", 64'(resp_valid), 64'd0);
         chk("midrst_rdata", resp_rdata, 64'd0);
         chk("midrst_err", 64'(resp_err), 64'd0);
         Reset = 1'b0;
         repeat (6) @(negedge Clk);
      end
      req(0, SZ_W, 0, 64'h80, 64'd0, 64'h00000000_55555555, 0);
      req(0, SZ_W, 0, 64'h84, 64'd0, 64'h00000000_12345678, 0);

      repeat (3) @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
